decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction decoder feeding a 2-entry skid buffer of decoded results
// Ports: clk, rst_n (sync, active-low); upstream in_valid/in_ready/instr/flush;
//   downstream out_valid/out_ready with alu_funct, rs1, rs2, rd, immed,
//   use_imm, reg_we, mem_re, mem_we, branch, jump, illegal.
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag undecodable instructions.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef INSTR_REG_WIDTH
`define INSTR_REG_WIDTH 5
`endif
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef ALU_FUNCT_ADD
`define ALU_FUNCT_ADD  4'd0
`define ALU_FUNCT_SUB  4'd1
`define ALU_FUNCT_SLL  4'd2
`define ALU_FUNCT_SLT  4'd3
`define ALU_FUNCT_SLTU 4'd4
`define ALU_FUNCT_XOR  4'd5
`define ALU_FUNCT_SRL  4'd6
`define ALU_FUNCT_SRA  4'd7
`define ALU_FUNCT_OR   4'd8
`define ALU_FUNCT_AND  4'd9
`endif
`ifndef FUNCT3_ADD
`define FUNCT3_ADD  3'b000
`define FUNCT3_SLL  3'b001
`define FUNCT3_SLT  3'b010
`define FUNCT3_SLTU 3'b011
`define FUNCT3_XOR  3'b100
`define FUNCT3_SRL  3'b101
`define FUNCT3_OR   3'b110
`define FUNCT3_AND  3'b111
`endif
`ifndef FUNCT7_ALT1
`define FUNCT7_ALT1 7'b0100000
`endif
`ifndef OPCODE_ALU_REG
`define OPCODE_ALU_REG 7'b0110011
`define OPCODE_ALU_IMM 7'b0010011
`define OPCODE_LOAD    7'b0000011
`define OPCODE_STORE   7'b0100011
`define OPCODE_BRANCH  7'b1100011
`define OPCODE_LUI     7'b0110111
`define OPCODE_AUIPC   7'b0010111
`define OPCODE_JAL     7'b1101111
`define OPCODE_JALR    7'b1100111
`endif
module decode_stage #(
  parameter int N = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [`INSTR_WIDTH-1:0]      instr,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [`ALU_FUNCT_WIDTH-1:0]  alu_funct,
  output logic [`INSTR_REG_WIDTH-1:0]  rs1,
  output logic [`INSTR_REG_WIDTH-1:0]  rs2,
  output logic [`INSTR_REG_WIDTH-1:0]  rd,
  output logic [N-1:0]                 immed,
  output logic                         use_imm,
  output logic                         reg_we,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic                         branch,
  output logic                         jump,
  output logic                         illegal
);
  typedef struct packed {
    logic [`ALU_FUNCT_WIDTH-1:0] alu_funct;
    logic [`INSTR_REG_WIDTH-1:0] rs1;
    logic [`INSTR_REG_WIDTH-1:0] rs2;
    logic [`INSTR_REG_WIDTH-1:0] rd;
    logic [N-1:0]                immed;
    logic                        use_imm;
    logic                        reg_we;
    logic                        mem_re;
    logic                        mem_we;
    logic                        branch;
    logic                        jump;
    logic                        illegal;
  } dec_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state_q, state_d;
  dec_t dec, e0_q, e0_d, e1_q, e1_d;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_reg, is_imm, is_load, is_store, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic known, alt, shift_imm, ill, in_x, out_x;
  logic [`ALU_FUNCT_WIDTH-1:0] alu_base;
  logic signed [31:0] imm32;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign is_reg = opc == `OPCODE_ALU_REG;
  assign is_imm = opc == `OPCODE_ALU_IMM;
  assign is_load = opc == `OPCODE_LOAD;
  assign is_store = opc == `OPCODE_STORE;
  assign is_br = opc == `OPCODE_BRANCH;
  assign is_lui = opc == `OPCODE_LUI;
  assign is_auipc = opc == `OPCODE_AUIPC;
  assign is_jal = opc == `OPCODE_JAL;
  assign is_jalr = opc == `OPCODE_JALR;
  assign known = is_reg | is_imm | is_load | is_store | is_br | is_lui | is_auipc | is_jal | is_jalr;
  assign alt = f7 == `FUNCT7_ALT1;
  assign shift_imm = is_imm && (f3 == `FUNCT3_SLL || f3 == `FUNCT3_SRL);
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign ill = !known || instr[1:0] != 2'b11 ||
               (is_reg && (f3 == `FUNCT3_ADD || f3 == `FUNCT3_SRL) && f7 != 7'b0 && !alt);
`else
  assign ill = 1'b0;
`endif
  // register forms use funct7 for SUB/SRA; immediate forms only look at bit 30 for SRAI
  assign alu_base = f3 == `FUNCT3_ADD ? ((is_reg && alt) ? `ALU_FUNCT_SUB : `ALU_FUNCT_ADD)
    : f3 == `FUNCT3_SLL ? `ALU_FUNCT_SLL
    : f3 == `FUNCT3_SLT ? `ALU_FUNCT_SLT
    : f3 == `FUNCT3_SLTU ? `ALU_FUNCT_SLTU
    : f3 == `FUNCT3_XOR ? `ALU_FUNCT_XOR
    : f3 == `FUNCT3_SRL ? ((is_reg ? alt : instr[30]) ? `ALU_FUNCT_SRA : `ALU_FUNCT_SRL)
    : f3 == `FUNCT3_OR ? `ALU_FUNCT_OR
    : `ALU_FUNCT_AND;
  // unknown opcodes fall through to the I-format immediate
  assign imm32 = is_store ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
    : is_br ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
    : (is_lui || is_auipc) ? {instr[31:12], 12'b0}
    : is_jal ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
    : {{20{instr[31]}}, instr[31:20]};
  always_comb begin
    dec = '0;
    dec.alu_funct = (is_reg || is_imm) ? alu_base : `ALU_FUNCT_ADD;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd = instr[11:7];
    dec.immed = is_reg ? '0 : shift_imm ? N'(instr[20 +: SHAMT_W]) : N'(imm32);
    dec.use_imm = known && !is_reg && !is_br;
    dec.reg_we = !ill && (is_reg | is_imm | is_load | is_lui | is_auipc | is_jal | is_jalr);
    dec.mem_re = !ill && is_load;
    dec.mem_we = !ill && is_store;
    dec.branch = !ill && is_br;
    dec.jump = !ill && (is_jal | is_jalr);
    dec.illegal = ill;
  end
  assign in_ready = state_q != FULL;
  // gated by rst_n so nothing leaves the stage during a reset cycle
  assign out_valid = rst_n && state_q != EMPTY;
  assign in_x = in_valid && in_ready;
  assign out_x = out_valid && out_ready;
  // e0 is always the head; e1 only holds the skid entry while FULL
  always_comb begin
    state_d = state_q;
    e0_d = e0_q;
    e1_d = e1_q;
    case (state_q)
      EMPTY: if (in_x) begin
        state_d = ONE;
        e0_d = dec;
      end
      ONE: if (in_x && !out_x) begin
        state_d = FULL;
        e1_d = dec;
      end else if (in_x) begin
        e0_d = dec;
      end else if (out_x) begin
        state_d = EMPTY;
      end
      FULL: if (out_x) begin
        state_d = ONE;
        e0_d = e1_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      state_q <= state_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign alu_funct = e0_q.alu_funct;
  assign rs1 = e0_q.rs1;
  assign rs2 = e0_q.rs2;
  assign rd = e0_q.rd;
  assign immed = e0_q.immed;
  assign use_imm = e0_q.use_imm;
  assign reg_we = e0_q.reg_we;
  assign mem_re = e0_q.mem_re;
  assign mem_we = e0_q.mem_we;
  assign branch = e0_q.branch;
  assign jump = e0_q.jump;
  assign illegal = e0_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven scoreboard bench for decode_stage
module tb_decode_stage;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif
  localparam int NV = 21;
  typedef struct packed {
    logic [3:0] alu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [31:0] imm;
    logic [6:0] fl;
  } exp_t;
  typedef struct {
    logic [31:0] instr;
    exp_t e;
  } vec_t;
  typedef struct {
    int tag;
    exp_t e;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, immed;
  logic [3:0] alu_funct;
  logic [4:0] rs1, rs2, rd;
  logic use_imm, reg_we, mem_re, mem_we, branch, jump, illegal;
  logic [57:0] got;
  vec_t tv[NV];
  sb_t sb[$];
  sb_t hd;
  exp_t cur_exp;
  int cur_tag, checks, errors, pops;
  decode_stage #(.N(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_funct(alu_funct),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immed(immed), .use_imm(use_imm), .reg_we(reg_we),
    .mem_re(mem_re), .mem_we(mem_we), .branch(branch), .jump(jump), .illegal(illegal)
  );
  assign got = {alu_funct, rs1, rs2, rd, immed, use_imm, reg_we, mem_re, mem_we, branch, jump, illegal};
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [3:0] a, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [31:0] im, input logic [6:0] fl);
    return '{a, s1, s2, d, im, fl};
  endfunction
  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, g, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int k);
    instr = tv[k].instr;
    cur_exp = tv[k].e;
    cur_tag = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic drain(input string nm, input int want);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0; n++) step();
    step();
    chk({nm, "_left"}, 64'(sb.size()), 0);
    chk({nm, "_count"}, 64'(pops), 64'(want));
  endtask
  // inputs change just after posedge, so the negedge view equals what the next edge samples
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", {63'b0, out_valid}, 0);
      else begin
        hd = sb.pop_front();
        pops++;
        chk($sformatf("dec_%0d", hd.tag), 64'(got), 64'(hd.e));
      end
    end
    if (!rst_n || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{cur_tag, cur_exp});
  end
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  initial begin
    // fl = {use_imm, reg_we, mem_re, mem_we, branch, jump, illegal}
    tv[0]  = '{32'h002081B3, mk(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0100000)};
    tv[1]  = '{32'h402081B3, mk(4'd1, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0100000)};
    tv[2]  = '{32'hFFF00093, mk(4'd0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 7'b1100000)};
    tv[3]  = '{32'h40335293, mk(4'd7, 5'd6, 5'd3, 5'd5, 32'h3, 7'b1100000)};
    tv[4]  = '{32'hFF812283, mk(4'd0, 5'd2, 5'd24, 5'd5, 32'hFFFFFFF8, 7'b1110000)};
    tv[5]  = '{32'h0070A623, mk(4'd0, 5'd1, 5'd7, 5'd12, 32'hC, 7'b1001000)};
    tv[6]  = '{32'hFE208EE3, mk(4'd0, 5'd1, 5'd2, 5'd29, 32'hFFFFFFFC, 7'b0000100)};
    tv[7]  = '{32'h12345537, mk(4'd0, 5'd8, 5'd3, 5'd10, 32'h12345000, 7'b1100000)};
    tv[8]  = '{32'h80000097, mk(4'd0, 5'd0, 5'd0, 5'd1, 32'h80000000, 7'b1100000)};
    tv[9]  = '{32'h008000EF, mk(4'd0, 5'd0, 5'd8, 5'd1, 32'h8, 7'b1100010)};
    tv[10] = '{32'hFFFFF06F, mk(4'd0, 5'd31, 5'd31, 5'd0, 32'hFFFFFFFE, 7'b1100010)};
    tv[11] = '{32'h004280E7, mk(4'd0, 5'd5, 5'd4, 5'd1, 32'h4, 7'b1100010)};
    tv[12] = '{32'h01F11093, mk(4'd2, 5'd2, 5'd31, 5'd1, 32'd31, 7'b1100000)};
    tv[13] = '{32'h0062C233, mk(4'd5, 5'd5, 5'd6, 5'd4, 32'h0, 7'b0100000)};
    tv[14] = '{32'h403150B3, mk(4'd7, 5'd2, 5'd3, 5'd1, 32'h0, 7'b0100000)};
    tv[15] = '{32'h003150B3, mk(4'd6, 5'd2, 5'd3, 5'd1, 32'h0, 7'b0100000)};
    tv[16] = '{32'h40010093, mk(4'd0, 5'd2, 5'd0, 5'd1, 32'h400, 7'b1100000)};
    tv[17] = '{32'hFF00F093, mk(4'd9, 5'd1, 5'd16, 5'd1, 32'hFFFFFFF0, 7'b1100000)};
    tv[18] = '{32'h00000000, mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, {6'b0, ILL})};
    tv[19] = '{32'h7FF0000B, mk(4'd0, 5'd0, 5'd31, 5'd0, 32'h7FF, {6'b0, ILL})};
    tv[20] = '{32'h022081B3, mk(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, {1'b0, !ILL, 4'b0, ILL})};
    checks = 0;
    errors = 0;
    pops = 0;
    cur_tag = 0;
    cur_exp = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    instr = '0;
    step();
    step();
    chk("rst_out_valid", {63'b0, out_valid}, 0);
    chk("rst_in_ready", {63'b0, in_ready}, 1);
    chk("rst_fields", 64'(got), 0);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      instr = tv[i].instr;
      cur_exp = tv[i].e;
      cur_tag = i;
      in_valid = 1'b1;
      step();
    end
    drain("stream", NV);
    out_ready = 1'b0;
    push(0);
    chk("stall_lat_valid", {63'b0, out_valid}, 1);
    chk("stall_one_ready", {63'b0, in_ready}, 1);
    chk("stall_headA", 64'(got), 64'(tv[0].e));
    push(1);
    chk("stall_full_ready", {63'b0, in_ready}, 0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("stall_hold_%0d", n), 64'(got), 64'(tv[0].e));
      chk($sformatf("stall_valid_%0d", n), {63'b0, out_valid}, 1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_headB", 64'(got), 64'(tv[1].e));
    chk("stall_B_valid", {63'b0, out_valid}, 1);
    step();
    chk("stall_empty_valid", {63'b0, out_valid}, 0);
    chk("stall_empty_ready", {63'b0, in_ready}, 1);
    out_ready = 1'b0;
    push(0);
    push(1);
    instr = tv[13].instr;
    cur_exp = tv[13].e;
    cur_tag = 13;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flushfull_valid", {63'b0, out_valid}, 0);
    chk("flushfull_ready", {63'b0, in_ready}, 1);
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("flushfull_quiet_%0d", n), {63'b0, out_valid}, 0);
    end
    out_ready = 1'b0;
    push(0);
    instr = tv[13].instr;
    cur_exp = tv[13].e;
    cur_tag = 13;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flushone_valid", {63'b0, out_valid}, 0);
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("flushone_quiet_%0d", n), {63'b0, out_valid}, 0);
    end
    out_ready = 1'b0;
    push(0);
    push(1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rstcyc_valid", {63'b0, out_valid}, 0);
    step();
    chk("rstmid_valid", {63'b0, out_valid}, 0);
    chk("rstmid_ready", {63'b0, in_ready}, 1);
    chk("rstmid_fields", 64'(got), 0);
    rst_n = 1'b1;
    step();
    chk("rstmid_after", {63'b0, out_valid}, 0);
    pops = 0;
    for (int i = 0; i < NV; i++) begin
      logic acc;
      instr = tv[i].instr;
      cur_exp = tv[i].e;
      cur_tag = 100 + i;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) begin
        acc = in_ready;
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
      chk($sformatf("bp_accept_%0d", i), {63'b0, acc}, 1);
    end
    drain("bp", NV);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
